// File: rtl/fpu_uart_pkg.sv
// Definitions shared by the FPU UART receive and transmit paths:
// FSM state encoding, default bit period and result word width.
package fpu_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 87;
    localparam int RESULT_W             = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Byte 0 is the low half of the result word, byte 1 the high half.
    function automatic logic [7:0] select_byte(input logic [RESULT_W-1:0] word,
                                               input logic                sel);
        return sel ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/fpu_result_uart_tx_if.sv
// Result-word handshake between the FPU and the UART transmitter.
// A word transfers on any rising clk edge where result_valid and result_ready are both high.
interface fpu_result_uart_tx_if;
    import fpu_uart_pkg::*;

    logic [RESULT_W-1:0] result_data;
    logic                result_valid;
    logic                result_ready;

    modport master (output result_data, output result_valid, input result_ready);
    modport slave  (input result_data, input result_valid, output result_ready);

endinterface

// File: rtl/fpu_result_uart_tx.sv
// Sends a 16-bit FPU result as two back-to-back 8N1 UART frames, low byte first.
// tx_serial and tx_done are registered; fsm_state exposes the sequencer state.
module fpu_result_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_W       = RESULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_result_uart_tx_if.slave  res,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    output tx_state_e            fsm_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic              byte_sel;
    logic [DATA_W-1:0] shadow;
    logic [7:0]        cur_byte;
    logic              baud_tick;
    logic              accept;

    assign cur_byte         = select_byte(shadow, byte_sel);
    assign baud_tick        = (baud_cnt == BAUD_LAST);
    assign res.result_ready = (state == IDLE) && !rst;
    assign accept           = res.result_valid && res.result_ready;
    assign tx_busy          = (state != IDLE);
    assign fsm_state        = state;

    // The line value for the next bit is loaded on the edge that enters it,
    // so tx_serial always changes exactly on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_sel  <= 1'b0;
            shadow    <= '0;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt  <= '0;
                    bit_idx   <= '0;
                    tx_serial <= 1'b1;
                    if (accept) begin
                        shadow    <= res.result_data;
                        byte_sel  <= 1'b0;
                        tx_serial <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        tx_serial <= cur_byte[0];
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            // High byte follows with no idle gap.
                            byte_sel  <= 1'b1;
                            tx_serial <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_serial <= 1'b1;
                            tx_done   <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx at 4 clocks per bit: table-driven words,
// back-to-back, busy-ignore and mid-frame reset sequences, plus a random loopback run.
module tb_fpu_result_uart_tx;
    import fpu_uart_pkg::*;

    localparam int CPB      = 4;
    localparam int WORD_CYC = 20 * CPB;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      tx_serial;
    logic      tx_busy;
    logic      tx_done;
    tx_state_e fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    vec_t       vecs[6];

    fpu_result_uart_tx_if res();

    fpu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .res       (res.slave),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- line decoder / scoreboard ----------------
    bit         mon_busy = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_serial === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2)
                check("start_bit", tx_serial, 1'b0);
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % CPB) == 0)
                mon_byte[(mon_cnt - 6) / CPB] = tx_serial;
            if (mon_cnt == 38) begin
                check("stop_bit", tx_serial, 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected no byte", mon_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("rx_byte", mon_byte, exp_b);
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [15:0] w, input logic [7:0] lo, input logic [7:0] hi,
                             input bit hold, output int acc);
        int guard;
        @(posedge clk);
        #1;
        res.result_data  = w;
        res.result_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!res.result_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", (guard < 200), 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(lo);
        exp_q.push_back(hi);
        if (!hold) res.result_valid = 1'b0;
    endtask

    // Called just after the accepting edge; ends on the negedge of the tx_done cycle.
    task automatic check_timing();
        for (int k = 0; k <= WORD_CYC; k++) begin
            @(negedge clk);
            check("tx_busy", tx_busy, (k < WORD_CYC));
            check("tx_done", tx_done, (k == WORD_CYC));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          acc;
        int          acc2;
        bit          saw_done;
        logic [15:0] w;

        vecs[0] = '{16'h3C00, 8'h00, 8'h3C};
        vecs[1] = '{16'h7E00, 8'h00, 8'h7E};
        vecs[2] = '{16'h8000, 8'h00, 8'h80};
        vecs[3] = '{16'h0001, 8'h01, 8'h00};
        vecs[4] = '{16'hA5C3, 8'hC3, 8'hA5};
        vecs[5] = '{16'hFFFF, 8'hFF, 8'hFF};

        res.result_valid = 1'b0;
        res.result_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_serial", tx_serial, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_ready", res.result_ready, 1'b0);
        check("rst_state", fsm_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", res.result_ready, 1'b1);

        // Table-driven single words
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, vecs[i].lo, vecs[i].hi, 1'b0, acc);
            check_timing();
        end

        // Back-to-back with valid held
        send_word(16'hC000, 8'h00, 8'hC0, 1'b1, acc);
        res.result_data = 16'h7BFF;
        for (int k = 0; k <= WORD_CYC; k++) begin
            @(negedge clk);
            if (k == WORD_CYC - 1) check("b2b_last_stop", tx_serial, 1'b1);
            if (k == WORD_CYC) begin
                check("b2b_done", tx_done, 1'b1);
                check("b2b_ready", res.result_ready, 1'b1);
                check("b2b_gap", tx_serial, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        acc2 = cyc;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7B);
        res.result_valid = 1'b0;
        check("b2b_accept_cycle", acc2 - acc, WORD_CYC + 1);
        check("b2b_busy_after", tx_busy, 1'b1);
        check_timing();

        // Valid and new data while busy are ignored
        send_word(16'h1234, 8'h34, 8'h12, 1'b0, acc);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        res.result_valid = 1'b1;
        res.result_data  = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("busy_ready_low", res.result_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        res.result_valid = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < WORD_CYC && !saw_done; k++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
        end
        check("busy_word_done", saw_done, 1'b1);
        check("busy_q_empty", exp_q.size(), 0);

        // Reset during bit 3 of the high byte
        send_word(16'h9C3A, 8'h3A, 8'h9C, 1'b0, acc);
        for (int k = 0; k < 57; k++) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_mid_low_received", exp_q.size(), 1);
        check("rst_mid_in_data", fsm_state, DATA);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_tx_serial", tx_serial, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        check("rst_mid_ready", res.result_ready, 1'b0);
        check("rst_mid_state", fsm_state, IDLE);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
        end
        check("rst_mid_no_done", saw_done, 1'b0);
        send_word(16'h0001, 8'h01, 8'h00, 1'b0, acc);
        check_timing();

        // Random loopback words
        for (int i = 0; i < 100; i++) begin
            w = 16'($urandom_range(0, 65535));
            send_word(w, w[7:0], w[15:8], 1'b0, acc);
            check_timing();
        end

        repeat (20) @(negedge clk);
        check("final_q_empty", exp_q.size(), 0);
        check("final_idle_line", tx_serial, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
